// File: rtl/trap_sequencer_if.sv
// trap_sequencer_if
//   Bundles the trap request, MRET, pipeline/fetch handshakes and the
//   software CSR port of trap_sequencer.
//   master : trap handler / pipeline side (drives requests, sees results)
//   slave  : trap_sequencer side
//   Signals:
//     cs, cause, trap_pc, trap_val  trap request and its payload
//     mret                          MRET committing
//     pipe_empty, redirect_ready    pipeline drained / fetch accepts redirect
//     csr_we, csr_addr, csr_wdata   software CSR write port
//     csr_rdata                     combinational CSR read data
//     flush, redirect_valid/pc      pipeline kill and fetch redirect
//     privilege, busy               current privilege, sequencer active
interface trap_sequencer_if #(
    parameter int unsigned XLEN = 64
);
    logic            cs;
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] trap_pc;
    logic [XLEN-1:0] trap_val;
    logic            mret;
    logic            pipe_empty;
    logic            redirect_ready;
    logic            csr_we;
    logic [11:0]     csr_addr;
    logic [XLEN-1:0] csr_wdata;
    logic [XLEN-1:0] csr_rdata;
    logic            flush;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic [1:0]      privilege;
    logic            busy;

    modport master (
        output cs, cause, trap_pc, trap_val, mret, pipe_empty, redirect_ready,
               csr_we, csr_addr, csr_wdata,
        input  csr_rdata, flush, redirect_valid, redirect_pc, privilege, busy
    );

    modport slave (
        input  cs, cause, trap_pc, trap_val, mret, pipe_empty, redirect_ready,
               csr_we, csr_addr, csr_wdata,
        output csr_rdata, flush, redirect_valid, redirect_pc, privilege, busy
    );
endinterface

// File: rtl/trap_sequencer.sv
// trap_sequencer
//   Machine-mode trap entry and MRET return sequencer. Owns mstatus
//   (MIE/MPIE/MPP), mtvec, mepc, mcause, mtval and the current privilege.
//   A trap or return runs flush -> CSR save/restore -> fetch redirect.
//   Ports:
//     clk    clock, all state changes on posedge
//     reset  synchronous, active-high
//     bus    trap_sequencer_if.slave (requests, handshakes, CSR port, outputs)
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | waiting for an accepted trap or MRET; software CSR writes allowed
//   FLUSH    | flush high until the pipeline reports empty
//   SAVE     | trap entry: write mepc/mcause/mtval, stack MIE, enter M-mode
//   RESTORE  | MRET: pop privilege and MIE from MPP/MPIE
//   REDIRECT | redirect_valid high with a stable PC until fetch accepts
module trap_sequencer #(
    parameter int unsigned     XLEN        = 64,
    parameter logic [XLEN-1:0] RESET_MTVEC = 64'h0000_0000_0000_0100
) (
    input logic            clk,
    input logic            reset,
    trap_sequencer_if.slave bus
);

    localparam logic [11:0] ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] ADDR_MEPC    = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] ADDR_MTVAL   = 12'h343;

    localparam logic [1:0] PRIV_U = 2'd0;
    localparam logic [1:0] PRIV_M = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_SAVE,
        ST_RESTORE,
        ST_REDIRECT
    } state_t;

    state_t          state;
    logic            ret_pending;
    logic [XLEN-1:0] cause_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] val_q;

    logic            mie;
    logic            mpie;
    logic [1:0]      mpp;
    logic [1:0]      priv;
    // mtvec[1] is always stored as 0; mtvec[0] is the vectored-mode flag
    logic [XLEN-1:0] mtvec;
    logic [XLEN-1:0] mepc;
    logic [XLEN-1:0] mcause;
    logic [XLEN-1:0] mtval;

    logic            flush_q;
    logic            redirect_valid_q;
    logic [XLEN-1:0] redirect_pc_q;
    logic            busy_q;

    logic            cs_accept;
    logic [XLEN-1:0] trap_target;
    logic [XLEN-1:0] mstatus_view;
    logic [XLEN-1:0] rdata;

    // Masked interrupts are only ignored while already in M-mode
    assign cs_accept = bus.cs && (!bus.cause[XLEN-1] || mie || (priv != PRIV_M));

    always_comb begin
        mstatus_view        = '0;
        mstatus_view[3]     = mie;
        mstatus_view[7]     = mpie;
        mstatus_view[12:11] = mpp;
    end

    // Vectored mode only offsets interrupts; the add wraps at XLEN bits
    always_comb begin
        trap_target = {mtvec[XLEN-1:2], 2'b00};
        if (mtvec[0] && cause_q[XLEN-1]) begin
            trap_target = trap_target + XLEN'({cause_q[5:0], 2'b00});
        end
    end

    always_comb begin
        rdata = '0;
        case (bus.csr_addr)
            ADDR_MSTATUS: rdata = mstatus_view;
            ADDR_MTVEC:   rdata = mtvec;
            ADDR_MEPC:    rdata = mepc;
            ADDR_MCAUSE:  rdata = mcause;
            ADDR_MTVAL:   rdata = mtval;
            default:      rdata = '0;
        endcase
    end

    assign bus.csr_rdata      = rdata;
    assign bus.flush          = flush_q;
    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.privilege      = priv;
    assign bus.busy           = busy_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= ST_IDLE;
            ret_pending      <= 1'b0;
            cause_q          <= '0;
            pc_q             <= '0;
            val_q            <= '0;
            mie              <= 1'b0;
            mpie             <= 1'b0;
            mpp              <= PRIV_U;
            priv             <= PRIV_M;
            mtvec            <= RESET_MTVEC;
            mepc             <= '0;
            mcause           <= '0;
            mtval            <= '0;
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            busy_q           <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cs_accept) begin
                        cause_q     <= bus.cause;
                        pc_q        <= bus.trap_pc;
                        val_q       <= bus.trap_val;
                        ret_pending <= 1'b0;
                        state       <= ST_FLUSH;
                        flush_q     <= 1'b1;
                        busy_q      <= 1'b1;
                    end else if (bus.mret) begin
                        ret_pending <= 1'b1;
                        state       <= ST_FLUSH;
                        flush_q     <= 1'b1;
                        busy_q      <= 1'b1;
                    end

                    if (bus.csr_we) begin
                        case (bus.csr_addr)
                            ADDR_MSTATUS: begin
                                mie  <= bus.csr_wdata[3];
                                mpie <= bus.csr_wdata[7];
                                // Only U and M exist; reserved MPP encodings collapse to U
                                mpp  <= (bus.csr_wdata[12:11] == PRIV_M) ? PRIV_M : PRIV_U;
                            end
                            ADDR_MTVEC: begin
                                mtvec <= {bus.csr_wdata[XLEN-1:2], 1'b0,
                                          (bus.csr_wdata[1:0] == 2'b01)};
                            end
                            ADDR_MEPC:   mepc   <= bus.csr_wdata & ~XLEN'(3);
                            ADDR_MCAUSE: mcause <= bus.csr_wdata;
                            ADDR_MTVAL:  mtval  <= bus.csr_wdata;
                            default: ;
                        endcase
                    end
                end

                ST_FLUSH: begin
                    if (bus.pipe_empty) begin
                        flush_q <= 1'b0;
                        state   <= ret_pending ? ST_RESTORE : ST_SAVE;
                    end
                end

                ST_SAVE: begin
                    mepc             <= pc_q & ~XLEN'(3);
                    mcause           <= cause_q;
                    mtval            <= val_q;
                    mpie             <= mie;
                    mie              <= 1'b0;
                    mpp              <= priv;
                    priv             <= PRIV_M;
                    redirect_pc_q    <= trap_target;
                    redirect_valid_q <= 1'b1;
                    state            <= ST_REDIRECT;
                end

                ST_RESTORE: begin
                    priv             <= mpp;
                    mie              <= mpie;
                    mpie             <= 1'b1;
                    mpp              <= PRIV_U;
                    redirect_pc_q    <= mepc;
                    redirect_valid_q <= 1'b1;
                    state            <= ST_REDIRECT;
                end

                ST_REDIRECT: begin
                    if (bus.redirect_ready) begin
                        redirect_valid_q <= 1'b0;
                        busy_q           <= 1'b0;
                        ret_pending      <= 1'b0;
                        state            <= ST_IDLE;
                    end
                end

                default: begin
                    state            <= ST_IDLE;
                    flush_q          <= 1'b0;
                    redirect_valid_q <= 1'b0;
                    busy_q           <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/trap_sequencer.md
Name: trap_sequencer

Overview:
- Consumes the trap handler's CS/CAUSE pair and performs machine-mode trap entry and MRET return.
- Owns the M-mode trap CSRs: mstatus (MIE/MPIE/MPP), mtvec, mepc, mcause, mtval, plus the current privilege level.
- Sequences flush -> CSR save -> PC redirect to the fetch stage, and feeds PRIVILEGE back to the trap handler.

Parameters:
- XLEN, 64, data/address width.
- RESET_MTVEC, 64'h0000_0000_0000_0100, mtvec value after reset.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RESET  in  1  synchronous, active-high reset.
- CS  in  1  trap request from the trap handler.
- CAUSE  in  XLEN  trap cause; bit XLEN-1 set means interrupt.
- TRAP_PC  in  XLEN  PC of the trapping instruction.
- TRAP_VAL  in  XLEN  faulting address or instruction bits, stored in mtval.
- MRET  in  1  MRET instruction committing.
- PIPE_EMPTY  in  1  pipeline has drained after FLUSH.
- REDIRECT_READY  in  1  fetch accepts the redirect.
- CSR_WE  in  1  software CSR write strobe.
- CSR_ADDR  in  12  CSR address.
- CSR_WDATA  in  XLEN  CSR write data.
- CSR_RDATA  out  XLEN  combinational CSR read data.
- FLUSH  out  1  kill in-flight instructions.
- REDIRECT_VALID  out  1  REDIRECT_PC is valid.
- REDIRECT_PC  out  XLEN  new fetch PC.
- PRIVILEGE  out  2  current privilege (0 = U, 3 = M).
- BUSY  out  1  high whenever state != IDLE.

Behaviour:
- Reset:
  - State IDLE, PRIVILEGE = 3, mstatus = 0, mtvec = RESET_MTVEC.
  - mepc, mcause, mtval = 0; latched cause/PC/val = 0.
  - FLUSH, REDIRECT_VALID, BUSY = 0; REDIRECT_PC = 0.
  - RESET asserted in any state returns to IDLE next edge and discards the pending trap or return.
- Accept rule (IDLE only):
  - Exceptions (CAUSE[63] = 0) are always accepted.
  - Interrupts (CAUSE[63] = 1) are accepted only if mstatus.MIE = 1 or PRIVILEGE < 3; otherwise ignored.
  - CS and MRET together: CS wins and MRET is dropped.
  - CS/MRET outside IDLE are ignored.
- FSM:
  - IDLE: on accepted CS, latch CAUSE, TRAP_PC, TRAP_VAL and go to FLUSH. On MRET, go to FLUSH with a return flag set.
  - FLUSH: FLUSH = 1. Advance to SAVE (trap) or RESTORE (return) on the first cycle PIPE_EMPTY = 1; minimum one cycle in FLUSH.
  - SAVE, one cycle:
    - mepc <= {pc[63:2], 2'b00}; mcause <= cause; mtval <= val.
    - MPIE <= MIE; MIE <= 0; MPP <= PRIVILEGE; PRIVILEGE <= 3.
    - Go to REDIRECT.
    - Target: if mtvec.MODE = 1 and cause is an interrupt, {BASE, 2'b00} + 4 * cause[5:0]; else {BASE, 2'b00}.
  - RESTORE, one cycle:
    - PRIVILEGE <= MPP; MIE <= MPIE; MPIE <= 1; MPP <= 0.
    - Target = mepc. Go to REDIRECT.
  - REDIRECT:
    - REDIRECT_VALID = 1 with REDIRECT_PC held stable.
    - On REDIRECT_READY = 1, return to IDLE next edge; REDIRECT_VALID drops.
- Minimum latency: CS accepted at cycle N (PIPE_EMPTY and READY already high) gives FLUSH at N+1, SAVE at N+2, REDIRECT_VALID at N+3, IDLE at N+4.
- Software CSR access:
  - Addresses: mstatus 0x300, mtvec 0x305, mepc 0x341, mcause 0x342, mtval 0x343.
  - Unmapped addresses read 0; writes to them are ignored.
  - Writes take effect only in IDLE; writes while BUSY are dropped.
  - mstatus: only bits 3 (MIE), 7 (MPIE) and 12:11 (MPP) are writable; other bits read 0. MPP values 1/2 are stored as 0.
  - mtvec: MODE in bits [1:0]; written values 2/3 store MODE = 0.
  - mepc: bits [1:0] are forced to 0.
  - CSR_RDATA reflects state before the current-edge update.
- Arithmetic: the vectored target add is XLEN-bit and wraps modulo 2^64 without error.

Test Plan:
- Reset, then read 0x305 -> 0x100; read 0x300 -> 0; PRIVILEGE = 3; all outputs 0.
- CS with CAUSE = 2, TRAP_PC = 0x8000_0006, TRAP_VAL = 0xDEAD, PIPE_EMPTY = 1, READY = 1 -> REDIRECT_PC = 0x100 at N+3; mepc = 0x8000_0004; mcause = 2; mtval = 0xDEAD; MIE = 0; MPP = 3.
- mtvec written to 0x201 (vectored), MIE = 1, CS with CAUSE = {1, 63'd7} -> REDIRECT_PC = 0x21C. Repeat with MIE = 0 in M-mode -> ignored, BUSY stays 0.
- PIPE_EMPTY held low 5 cycles -> FLUSH high 5 cycles, no CSR change. REDIRECT_READY low 3 cycles -> REDIRECT_PC stable throughout.
- After a trap from U-mode (MPP = 0, MPIE = 1), MRET -> PRIVILEGE = 0, MIE = 1, REDIRECT_PC = mepc. CS and MRET asserted together -> trap taken.
- RESET asserted during SAVE -> IDLE next cycle, register values as after reset. CSR_WE asserted while BUSY -> register unchanged.
